// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 32-entry register file.
package reg_file_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int REG_COUNT      = 32;
    localparam int DATA_W_DEFAULT = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_write_decode.sv
// One-hot write-enable decoder; entry 0 is hard-wired read-only.
module reg_write_decode
    import reg_file_pkg::*;
(
    input  logic                 wr_en,
    input  reg_addr_t            wr_addr,
    output logic [REG_COUNT-1:0] wr_sel
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        wr_sel = '0;
        if (wr_en) begin
            wr_sel[wr_addr] = 1'b1;
        end
        wr_sel[0] = 1'b0;
    end

endmodule

// File: rtl/reg_file.sv
// 32 x DATA_W register file: two combinational read ports, one write port, optional forwarding.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter bit BYPASS = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  reg_addr_t         ReadRegister1,
    input  reg_addr_t         ReadRegister2,
    input  reg_addr_t         WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    logic [DATA_W-1:0]    regs_q [REG_COUNT];
    logic [DATA_W-1:0]    regs_d [REG_COUNT];
    logic [REG_COUNT-1:0] wr_sel;
    logic                 wr_en;

    // A write in progress while reset is low must neither land nor forward.
    assign wr_en = RegWrite & Reset_n;

    reg_write_decode u_decode (
        .wr_en   (wr_en),
        .wr_addr (WriteRegister),
        .wr_sel  (wr_sel)
    );

    always_comb begin
        // NOTE: blocking assignments here; this only builds next-state, the flops below use <=.
        regs_d = regs_q;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (wr_sel[i]) begin
                regs_d[i] = WriteData;
            end
        end
    end

    // NOTE: this storage is reset on purpose (every entry must read 0 at once), so it maps to flops, not RAM.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        ReadData1 = regs_q[ReadRegister1];
        if (BYPASS && wr_en && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteData;
        end
        if ((ReadRegister1 == REG_ZERO) || !Reset_n) begin
            ReadData1 = '0;
        end
    end

    always_comb begin
        ReadData2 = regs_q[ReadRegister2];
        if (BYPASS && wr_en && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteData;
        end
        if ((ReadRegister2 == REG_ZERO) || !Reset_n) begin
            ReadData2 = '0;
        end
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register and data width in bits.
REQ-002 Parameter BYPASS, default 1, SHALL select write-to-read forwarding: 1 = forward, 0 = no forward.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 ReadRegister1  input  5  SHALL be the read address for port 1.
REQ-006 ReadRegister2  input  5  SHALL be the read address for port 2.
REQ-007 WriteRegister  input  5  SHALL be the write destination, driven by the upstream 5-bit destination-select mux.
REQ-008 WriteData  input  DATA_W  SHALL be the write-back value.
REQ-009 RegWrite  input  1  SHALL be the write enable, active high.
REQ-010 ReadData1  output  DATA_W  SHALL carry the port-1 read value.
REQ-011 ReadData2  output  DATA_W  SHALL carry the port-2 read value.

Function
REQ-012 The block SHALL hold 32 registers of DATA_W bits, indexed 0-31.
REQ-013 On a rising Clk edge with RegWrite=1, Reset_n=1 and WriteRegister!=0, the block SHALL load WriteData into register[WriteRegister].
REQ-014 The block SHALL ignore writes to register 0; register 0 SHALL always read as 0.
REQ-015 When RegWrite=0, the block SHALL ignore WriteRegister and WriteData, including X or Z values, and state SHALL be unchanged.
REQ-016 Reads SHALL be combinational with zero-cycle latency: ReadDataN = register[ReadRegisterN].
REQ-017 If BYPASS=1, RegWrite=1 and WriteRegister==ReadRegisterN!=0, ReadDataN SHALL equal WriteData in the same cycle.
REQ-018 If BYPASS=0 in the same case, ReadDataN SHALL show the old value until after the edge.
REQ-019 Both ports SHALL read the same address simultaneously and return identical data.
REQ-020 A write SHALL change exactly one register; all others SHALL hold their values.

Reset
REQ-021 Reset_n=0 SHALL clear all 32 registers to 0 immediately, without waiting for Clk.
REQ-022 While Reset_n=0, ReadData1 and ReadData2 SHALL read 0, and writes (including bypass) SHALL be suppressed.
REQ-023 Reset asserted in the same cycle as a write SHALL win; the register SHALL be 0 afterwards.
REQ-024 After Reset_n is deasserted, the first rising Clk edge SHALL be able to perform a write.

Structure
REQ-025 A shared package SHALL hold the REG_ADDR_W=5 and REG_COUNT=32 constants, the REG_ZERO=5'd0 constant and the DATA_W default.
REQ-026 The block SHALL contain one sub-module, reg_write_decode, a 5-to-32 one-hot write-enable decoder gated by RegWrite, with bit 0 forced low.
REQ-027 The block SHALL contain no other sub-modules; the read paths SHALL be 32:1 selects inside reg_file.

Verification
REQ-028 Reset test: pulse Reset_n low mid-cycle after writing 0xDEADBEEF to r5 -> ReadData1 (addr 5) = 0 before the next Clk edge.
REQ-029 Write/read test: write 0x12345678 to r8, then read r8 on both ports -> both ports = 0x12345678; r9 = 0.
REQ-030 Zero-register test: write 0xFFFFFFFF to r0 with RegWrite=1 -> ReadData1 (addr 0) = 0.
REQ-031 Bypass test: BYPASS=1, r3=0x11, write 0x22 to r3 while reading r3 -> ReadData1 = 0x22 before the edge. With BYPASS=0 -> 0x11 before the edge, 0x22 after.
REQ-032 Enable test: RegWrite=0, WriteRegister=X, WriteData=0xAAAA -> all 32 registers unchanged.
REQ-033 Sweep test: write value i*0x01010101 to each register i=1..31, then read back pairwise on both ports -> every value matches and r0 = 0.
